// File: rtl/pipe_perf_monitor.sv
// Per-stage instruction-event counters with a sticky pass/fail/watchdog verdict FSM.
// cnt_out has one cycle of registered latency; no backpressure, and events are dropped once done=1.
module pipe_perf_monitor #(
    parameter  int NSTAGE = 4,
    parameter  int CNT_W  = 32,
    parameter  int PC_W   = 32,
    parameter  int WDOG_W = 16,
    localparam int SEL_W  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [NSTAGE-1:0] stage_v,
    input  logic              pc_v,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   pass_pc,
    input  logic [PC_W-1:0]   fail_pc,
    input  logic [WDOG_W-1:0] wdog_limit,
    input  logic [SEL_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]  cnt_out,
    output logic [2:0]        state,
    output logic              done,
    output logic [NSTAGE-1:0] sat
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [CNT_W-1:0]  cnt [NSTAGE];
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_inc;
    logic              retire;
    logic              run_active;
    logic              fail_hit;
    logic              pass_hit;
    logic              wdog_fire;
    logic              wipe;

    assign wipe       = !reset || clear;
    assign retire     = stage_v[NSTAGE-1];
    assign run_active = (cur_state == S_RUN) && enable;
    assign fail_hit   = pc_v && (pc_i == fail_pc);
    assign pass_hit   = pc_v && (pc_i == pass_pc);

    // Watchdog compare uses the value it would take this edge, so limit=N fires on the Nth idle cycle.
    always_comb begin
        wdog_inc  = (&wdog) ? wdog : wdog + 1'b1;
        wdog_fire = !retire && (wdog_limit != '0) && (wdog_inc == wdog_limit);
    end

    always_ff @(posedge clk) begin
        if (wipe) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (enable) nxt_state = S_RUN;
            end
            S_RUN: begin
                if (!enable)        nxt_state = S_IDLE;
                else if (fail_hit)  nxt_state = S_FAIL;
                else if (pass_hit)  nxt_state = S_PASS;
                else if (wdog_fire) nxt_state = S_TIMEOUT;
            end
            S_PASS, S_FAIL, S_TIMEOUT: nxt_state = cur_state;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        state = cur_state;
        done  = (cur_state == S_PASS) || (cur_state == S_FAIL) || (cur_state == S_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (wipe) begin
            for (int k = 0; k < NSTAGE; k++) cnt[k] <= '0;
            sat <= '0;
        end else if (run_active) begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (stage_v[k]) begin
                    if (&cnt[k]) sat[k] <= 1'b1;
                    else         cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wipe) begin
            wdog <= '0;
        end else if (run_active) begin
            wdog <= retire ? '0 : wdog_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (wipe) begin
            cnt_out <= '0;
        end else if (int'(cnt_sel) < NSTAGE) begin
            cnt_out <= cnt[cnt_sel];
        end else begin
            cnt_out <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_perf_monitor;

    localparam int NS = 4;
    localparam longint CMAX = 64'hFFFF_FFFF;
    localparam int WMAX = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  stage_v = '0;
    logic        pc_v = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] pass_pc = 32'h8000_0044;
    logic [31:0] fail_pc = 32'h8000_0048;
    logic [15:0] wdog_limit = '0;
    logic [1:0]  cnt_sel = '0;
    logic [31:0] cnt_out;
    logic [2:0]  state;
    logic        done;
    logic [3:0]  sat;
    logic [3:0]  cnt_out4;
    logic [2:0]  state4;
    logic        done4;
    logic [3:0]  sat4;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_state = 0;
    longint      m_cnt [NS];
    logic [3:0]  m_sat = '0;
    int          m_idle = 0;
    logic [31:0] m_out = '0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.NSTAGE(4), .CNT_W(32), .PC_W(32), .WDOG_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stage_v(stage_v),
        .pc_v(pc_v), .pc_i(pc_i), .pass_pc(pass_pc), .fail_pc(fail_pc),
        .wdog_limit(wdog_limit), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
        .state(state), .done(done), .sat(sat)
    );

    pipe_perf_monitor #(.NSTAGE(4), .CNT_W(4), .PC_W(32), .WDOG_W(16)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stage_v(stage_v),
        .pc_v(pc_v), .pc_i(pc_i), .pass_pc(pass_pc), .fail_pc(fail_pc),
        .wdog_limit(wdog_limit), .cnt_sel(cnt_sel), .cnt_out(cnt_out4),
        .state(state4), .done(done4), .sat(sat4)
    );

    task automatic model_update();
        logic [31:0] nout;
        bit timeout;
        timeout = 1'b0;
        if (!reset || clear) begin
            m_state = 0;
            for (int k = 0; k < NS; k++) m_cnt[k] = 0;
            m_sat  = '0;
            m_idle = 0;
            m_out  = '0;
        end else begin
            nout = m_cnt[cnt_sel][31:0];
            if (m_state == 0) begin
                if (enable) m_state = 1;
            end else if (m_state == 1) begin
                if (!enable) begin
                    m_state = 0;
                end else begin
                    for (int k = 0; k < NS; k++) begin
                        if (stage_v[k]) begin
                            if (m_cnt[k] == CMAX) m_sat[k] = 1'b1;
                            else m_cnt[k] = m_cnt[k] + 1;
                        end
                    end
                    if (stage_v[NS-1]) begin
                        m_idle = 0;
                    end else begin
                        if (m_idle < WMAX) m_idle = m_idle + 1;
                        timeout = (wdog_limit != 0) && (m_idle == int'(wdog_limit));
                    end
                    if (pc_v && pc_i == fail_pc)      m_state = 3;
                    else if (pc_v && pc_i == pass_pc) m_state = 2;
                    else if (timeout)                 m_state = 4;
                end
            end
            m_out = nout;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cnt(input logic [1:0] sel, output logic [31:0] v, output logic [3:0] v4);
        stage_v = '0;
        cnt_sel = sel;
        tick();
        v  = cnt_out;
        v4 = cnt_out4;
    endtask

    task automatic do_clear();
        pc_v = 1'b0; stage_v = '0; enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [3:0]  v4;
        reset = 1'b0; enable = 1'b1; stage_v = 4'b1111;
        tick(); tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", done); end
        checks++; if (sat !== 4'b0) begin errors++; $display("FAIL reset_sat got %b want 0000", sat); end
        checks++; if (cnt_out !== 32'd0) begin errors++; $display("FAIL reset_cnt_out got %0d want 0", cnt_out); end
        reset = 1'b1; enable = 1'b0;
        for (int s = 0; s < NS; s++) begin
            read_cnt(2'(s), v, v4);
            checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_cnt%0d got %0d want 0", s, v); end
        end
    endtask

    task automatic test_counting();
        logic [31:0] v;
        logic [3:0]  v4;
        logic [31:0] exp_c [NS];
        exp_c[0] = 15; exp_c[1] = 10; exp_c[2] = 15; exp_c[3] = 10;
        do_clear();
        enable = 1'b1; tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL count_run got %0d want 1", state); end
        stage_v = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        stage_v = 4'b0101;
        for (int i = 0; i < 5; i++) tick();
        for (int s = 0; s < NS; s++) begin
            read_cnt(2'((s + 2) % NS), v, v4);
            checks++;
            if (v !== exp_c[(s + 2) % NS]) begin
                errors++;
                $display("FAIL count_sel%0d got %0d want %0d", (s + 2) % NS, v, exp_c[(s + 2) % NS]);
            end
        end
    endtask

    task automatic test_pass();
        logic [31:0] v;
        logic [3:0]  v4;
        do_clear();
        pass_pc = 32'h8000_0044; fail_pc = 32'h8000_0048;
        enable = 1'b1; tick();
        stage_v = 4'b1111; pc_v = 1'b1; pc_i = 32'h8000_0044;
        tick();
        pc_v = 1'b0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pass_state got %0d want 2", state); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got %0d want 1", done); end
        for (int i = 0; i < 3; i++) tick();
        read_cnt(2'd0, v, v4);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL pass_cnt0 got %0d want 1", v); end
        read_cnt(2'd3, v, v4);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL pass_cnt3 got %0d want 1", v); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pass_sticky got %0d want 2", state); end
        clear = 1'b1; enable = 1'b1; tick(); clear = 1'b0; enable = 1'b0;
        checks++; if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL pass_clear got %0d/%0d want 0/0", state, done); end
        read_cnt(2'd0, v, v4);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL pass_clear_cnt got %0d want 0", v); end
    endtask

    task automatic test_fail_priority();
        do_clear();
        pass_pc = 32'h100; fail_pc = 32'h100;
        enable = 1'b1; tick();
        pc_v = 1'b1; pc_i = 32'h100; tick(); pc_v = 1'b0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL samepc_state got %0d want 3", state); end
        do_clear();
        pass_pc = 32'h8000_0044; fail_pc = 32'h8000_0048; wdog_limit = 16'd8;
        enable = 1'b1; tick();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL failwd_pre got %0d want 1", state); end
        pc_v = 1'b1; pc_i = 32'h8000_0048; tick(); pc_v = 1'b0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL failwd_state got %0d want 3", state); end
        wdog_limit = '0;
    endtask

    task automatic test_watchdog();
        logic seen_done;
        do_clear();
        wdog_limit = 16'd8; enable = 1'b1; tick();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL wd_7idle got %0d want 1", state); end
        tick();
        checks++; if (state !== 3'd4 || done !== 1'b1) begin errors++; $display("FAIL wd_8idle got %0d/%0d want 4/1", state, done); end
        do_clear();
        enable = 1'b1; tick();
        seen_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            stage_v = (i % 7 == 6) ? 4'b1000 : 4'b0000;
            tick();
            seen_done |= done;
        end
        checks++; if (seen_done !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL wd_retire7 got done=%0d state=%0d want 0/1", seen_done, state); end
        do_clear();
        wdog_limit = 16'd1; enable = 1'b1; tick(); tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL wd_limit1 got %0d want 4", state); end
        do_clear();
        wdog_limit = '0; enable = 1'b1; tick();
        seen_done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            seen_done |= done;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL wd_disabled got done=%0d want 0", seen_done); end
    endtask

    task automatic test_sat_pause();
        logic [31:0] v;
        logic [3:0]  v4;
        do_clear();
        enable = 1'b1; tick();
        stage_v = 4'b0001;
        for (int i = 0; i < 14; i++) tick();
        read_cnt(2'd0, v, v4);
        checks++; if (v4 !== 4'd14 || sat4 !== 4'b0000) begin errors++; $display("FAIL sat_14 got %0d sat=%b want 14 sat=0000", v4, sat4); end
        stage_v = 4'b0001;
        for (int i = 0; i < 6; i++) tick();
        read_cnt(2'd0, v, v4);
        checks++; if (v4 !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d want 15", v4); end
        checks++; if (sat4 !== 4'b0001) begin errors++; $display("FAIL sat_flag got %b want 0001", sat4); end
        checks++; if (v !== 32'd20 || sat !== 4'b0000) begin errors++; $display("FAIL sat_wide got %0d sat=%b want 20 sat=0000", v, sat); end
        enable = 1'b0; tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL pause_state got %0d want 0", state); end
        stage_v = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        read_cnt(2'd0, v, v4);
        checks++; if (v !== 32'd20) begin errors++; $display("FAIL pause_hold got %0d want 20", v); end
        enable = 1'b1; stage_v = '0; tick();
        stage_v = 4'b0001; tick(); tick();
        read_cnt(2'd0, v, v4);
        checks++; if (v !== 32'd22 || state !== 3'd1) begin errors++; $display("FAIL resume got %0d state=%0d want 22/1", v, state); end
    endtask

    task automatic test_random();
        logic [31:0] pcs [3];
        do_clear();
        wdog_limit = 16'($urandom_range(4, 20));
        for (int i = 0; i < 2000; i++) begin
            reset   = ($urandom_range(0, 299) != 0);
            clear   = ($urandom_range(0, 59) == 0);
            enable  = ($urandom_range(0, 11) != 0);
            stage_v = 4'($urandom);
            if ($urandom_range(0, 2) == 0) stage_v[3] = 1'b0;
            cnt_sel = 2'($urandom);
            if ($urandom_range(0, 49) == 0) wdog_limit = 16'($urandom_range(0, 24));
            if ($urandom_range(0, 99) == 0) begin
                pass_pc = 32'($urandom_range(0, 3)) << 2;
                fail_pc = 32'($urandom_range(0, 3)) << 2;
            end
            pcs[0] = pass_pc; pcs[1] = fail_pc; pcs[2] = $urandom;
            pc_v = ($urandom_range(0, 29) == 0);
            pc_i = pcs[$urandom_range(0, 2)];
            tick();
            checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, state, m_state); end
            checks++; if (done !== (m_state >= 2)) begin errors++; $display("FAIL rnd_done cyc %0d got %0d want %0d", i, done, m_state >= 2); end
            checks++; if (sat !== m_sat) begin errors++; $display("FAIL rnd_sat cyc %0d got %b want %b", i, sat, m_sat); end
            checks++; if (cnt_out !== m_out) begin errors++; $display("FAIL rnd_cnt_out cyc %0d got %0d want %0d", i, cnt_out, m_out); end
        end
        reset = 1'b1; clear = 1'b0; pc_v = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NS; k++) m_cnt[k] = 0;
        test_reset();
        test_counting();
        test_pass();
        test_fail_priority();
        test_watchdog();
        test_sat_pause();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Synthesizable, parametrised per-stage instruction-event monitor for the RISC-V core; sits beside the cpu in simulation top and FPGA builds.
- Counts valid (non-stalled) instructions per pipeline stage in NSTAGE counters.
- Detects pass/fail PC hits and a commit watchdog timeout; reports one sticky verdict via a small FSM.
- Counters are readable through a select mux and freeze when a verdict is reached.

Parameters:
- NSTAGE, 4, number of pipeline-stage event inputs; index NSTAGE-1 is the retire stage.
- CNT_W, 32, width of each stage counter.
- PC_W, 32, width of PC compare values.
- WDOG_W, 16, width of the watchdog counter and its limit.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  counting and detection active when 1
- clear  input  1  synchronous clear of counters, watchdog and verdict; ignored while reset=0
- stage_v  input  NSTAGE  per-stage valid-and-not-stalled strobe
- pc_v  input  1  pc_i qualifier; fetch-stage valid
- pc_i  input  PC_W  fetch-stage PC
- pass_pc  input  PC_W  PC that signals PASS
- fail_pc  input  PC_W  PC that signals FAIL
- wdog_limit  input  WDOG_W  retire-idle cycle limit; 0 disables the watchdog
- cnt_sel  input  $clog2(NSTAGE)  counter read select
- cnt_out  output  CNT_W  registered value of counter[cnt_sel]
- state  output  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
- done  output  1  1 in PASS, FAIL or TIMEOUT
- sat  output  NSTAGE  per-counter sticky saturation flag

Behaviour:
- Reset (reset=0 at a clk edge): all counters, sat, watchdog and cnt_out go to 0; state goes to IDLE; done goes to 0.
- clear=1 with reset=1: same effect as reset on the next edge, and it overrides all other events in that cycle.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0; counters and watchdog hold.
  - RUN -> FAIL when pc_v=1 and pc_i==fail_pc.
  - RUN -> PASS when pc_v=1 and pc_i==pass_pc.
  - RUN -> TIMEOUT when the watchdog reaches the limit.
  - PASS, FAIL and TIMEOUT are sticky until clear or reset; done=1 in these states.
- Priority within one RUN cycle: FAIL > PASS > TIMEOUT. If pass_pc==fail_pc, a hit gives FAIL.
- Counting: in RUN only, each stage_v[k]=1 increments counter[k] by 1 on that edge.
  - Events in the cycle of the verdict-causing transition are still counted.
  - No events are counted once done=1.
- Saturation: a counter at 2^CNT_W-1 holds its value and sets sat[k]; no wrap.
- Watchdog, RUN only:
  - Resets to 0 on any cycle with stage_v[NSTAGE-1]=1; otherwise increments.
  - When wdog_limit!=0 and the post-increment value equals wdog_limit, the next state is TIMEOUT.
  - wdog_limit=0: watchdog never fires.
  - The watchdog counter saturates at all-ones.
- cnt_out: registered, one-cycle latency from cnt_sel or counter change; it reflects the counter value after the previous edge.
  - cnt_sel >= NSTAGE reads 0.
- Stage ordering is not checked; a downstream count exceeding an upstream one is legal (flushes, replays).
- Changes to pass_pc, fail_pc or wdog_limit take effect from the next compare.

Test Plan:
- Reset: reset=0 for 2 cycles with stage_v=all ones and enable=1 -> all cnt_out=0, state=0, done=0, sat=0.
- Counting: enable=1; stage_v=4'b1111 for 10 cycles, then 4'b0101 for 5 cycles -> counters {15,10,15,10} for stages 0..3; cnt_out for sel=2 is 15, one cycle after the select.
- Pass: pc_v=1 with pc_i=pass_pc=0x80000044 in cycle N -> state=2 and done=1 after edge N; stage_v events in cycle N are counted, events after that are not; clear returns state to 0.
- Fail priority: pass_pc=fail_pc=0x100 hit -> state=3. Separately, a fail hit in the same cycle the watchdog fires -> state=3.
- Watchdog: wdog_limit=8, retire strobe idle -> state=4 after the 8th idle RUN cycle. With a retire every 7 cycles -> no timeout over 100 cycles. With wdog_limit=0 -> no timeout over 1000 cycles.
- Saturation and pause: CNT_W=4, 20 stage-0 events -> counter 15, sat[0]=1. Toggling enable to 0 mid-run -> state=0 and counts hold; re-enabling resumes from the held values.
